// File: rtl/sha_ctrl_pkg.sv
// rtl/sha_ctrl_pkg.sv - shared state encoding and sizing constants for the SHA job sequencer
package sha_ctrl_pkg;

  localparam int SHA_MSG_WORDS  = 16;
  localparam int SHA_HASH_WORDS = 8;
  localparam int SHA_WORD_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_RST    = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } sha_state_e;

endpackage

// File: rtl/sha_job_sequencer.sv
// rtl/sha_job_sequencer.sv - loads one 512-bit block, sequences the SHA-256 core reset/run, captures the digest
module sha_job_sequencer
  import sha_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [31:0]    wr_data,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           timeout,
  input  logic [2:0]     rd_idx,
  output logic [31:0]    rd_data,
  output logic [0:511]   core_message,
  output logic           core_reset,
  input  logic           core_ready,
  input  logic [255:0]   core_hash
);

  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]      RST_LAST = 4'(RESET_CYCLES - 1);
  localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  sha_state_e       r_state;
  sha_state_e       w_state_nxt;
  logic [4:0]       r_wcnt;
  logic [3:0]       r_rst_cnt;
  logic [CW-1:0]    r_cyc;
  logic [0:511]     r_msg;
  logic [255:0]     r_digest;

  logic             w_wr_fire;
  logic             w_reload;
  logic             w_ready_q;
  logic [8:0]       w_base;
  logic [7:0]       w_rd_msb;

  assign w_wr_fire = wr_valid && wr_ready;
  assign w_reload  = w_wr_fire && ((r_state == ST_DONE) || (r_state == ST_ERR));
  // The first RUN cycle (r_cyc == 0) masks a ready left over from the previous job.
  assign w_ready_q = (r_state == ST_RUN) && (r_cyc != '0) && core_ready;
  assign w_base    = {r_wcnt[3:0], 5'b00000};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    core_reset  = 1'b1;
    case (r_state)
      ST_IDLE: begin
        wr_ready = (r_wcnt < 5'd16);
        if (w_wr_fire && (r_wcnt == 5'd15)) begin
          w_state_nxt = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (start) begin
          w_state_nxt = ST_RST;
        end
      end
      ST_RST: begin
        busy = 1'b1;
        if (r_rst_cnt == RST_LAST) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy       = 1'b1;
        core_reset = 1'b0;
        if (w_ready_q) begin
          w_state_nxt = ST_DONE;
        end else if (r_cyc == TO_LAST) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_DONE: begin
        wr_ready   = 1'b1;
        done       = 1'b1;
        core_reset = 1'b0;
        if (w_wr_fire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        wr_ready = 1'b1;
        timeout  = 1'b1;
        if (w_wr_fire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt    <= 5'd0;
      r_rst_cnt <= 4'd0;
      r_cyc     <= '0;
      r_msg     <= '0;
      r_digest  <= '0;
    end else begin
      // A word arriving after a finished job always restarts the load at word0.
      if (w_reload) begin
        r_msg[0 +: 32] <= wr_data;
        r_wcnt         <= 5'd1;
      end else if (w_wr_fire) begin
        r_msg[w_base +: 32] <= wr_data;
        r_wcnt              <= r_wcnt + 5'd1;
      end

      if (r_state == ST_RST) begin
        r_rst_cnt <= r_rst_cnt + 4'd1;
      end else begin
        r_rst_cnt <= 4'd0;
      end

      if (r_state == ST_RUN) begin
        r_cyc <= r_cyc + 1'b1;
      end else begin
        r_cyc <= '0;
      end

      if (w_ready_q) begin
        r_digest <= core_hash;
      end
    end
  end

  // Word i occupies digest bits [255-32i -: 32]; 255-32i == {~i, 5'h1f}.
  assign w_rd_msb     = {~rd_idx, 5'h1f};
  assign rd_data      = r_digest[w_rd_msb -: 32];
  assign core_message = r_msg;

endmodule

// File: tb/tb_sha_job_sequencer.sv
// tb/tb_sha_job_sequencer.sv - self-checking bench for sha_job_sequencer
`timescale 1ns/100ps
module tb_sha_job_sequencer;

  localparam int RST_A = 2;
  localparam int RST_B = 3;
  localparam int TO_B  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           wr_valid;
  logic [31:0]    wr_data;
  logic           start;
  logic [2:0]     rd_idx;
  logic           core_ready;
  logic [255:0]   core_hash;

  logic           a_wr_ready, a_busy, a_done, a_timeout, a_core_reset;
  logic [31:0]    a_rd_data;
  logic [0:511]   a_core_message;
  logic           b_wr_ready, b_busy, b_done, b_timeout, b_core_reset;
  logic [31:0]    b_rd_data;
  logic [0:511]   b_core_message;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]    msg_w [16];
  logic [31:0]    hw [8];
  logic [0:511]   exp_msg;

  always #10 clk = ~clk;

  sha_job_sequencer u_dut_a (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(a_wr_ready), .wr_data(wr_data),
    .start(start), .busy(a_busy), .done(a_done), .timeout(a_timeout), .rd_idx(rd_idx),
    .rd_data(a_rd_data), .core_message(a_core_message), .core_reset(a_core_reset),
    .core_ready(core_ready), .core_hash(core_hash)
  );

  sha_job_sequencer #(.RESET_CYCLES(RST_B), .TIMEOUT_CYCLES(TO_B)) u_dut_b (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_data(wr_data),
    .start(start), .busy(b_busy), .done(b_done), .timeout(b_timeout), .rd_idx(rd_idx),
    .rd_data(b_rd_data), .core_message(b_core_message), .core_reset(b_core_reset),
    .core_ready(1'b0), .core_hash(~core_hash)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic build_exp();
    exp_msg = '0;
    for (int k = 0; k < 16; k++) exp_msg[32*k +: 32] = msg_w[k];
  endtask

  task automatic random_block();
    for (int k = 0; k < 16; k++) msg_w[k] = $urandom;
    build_exp();
  endtask

  task automatic random_hash();
    for (int i = 0; i < 8; i++) hw[i] = $urandom;
    core_hash = {hw[0], hw[1], hw[2], hw[3], hw[4], hw[5], hw[6], hw[7]};
  endtask

  task automatic check_digest(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      chk($sformatf("%s_rd%0d", tag, i), a_rd_data, hw[i]);
    end
    chk({tag, "_b_rd"}, b_rd_data, 32'h0);
  endtask

  task automatic run_job(input int n, input bit stale, input string tag);
    int i, a_cnt, a_rst, b_cnt;
    a_cnt = 0; a_rst = 0; b_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    i = 1;
    while ((a_busy || b_busy) && i < 3000) begin
      if (a_busy) a_cnt++;
      if (a_busy && a_core_reset) a_rst++;
      if (b_busy) b_cnt++;
      if (!stale) core_ready = (i > RST_A) && (i - RST_A == n);
      tick();
      i++;
    end
    if (!stale) core_ready = 1'b0;
    chk({tag, "_bound"}, i < 3000, 1);
    chk({tag, "_busy_cycles"}, a_cnt, RST_A + (stale ? 2 : n));
    chk({tag, "_rst_cycles"}, a_rst, RST_A);
    chk({tag, "_b_busy_cycles"}, b_cnt, RST_B + TO_B);
    chk({tag, "_done"}, {a_done, a_timeout, a_core_reset}, 3'b100);
    chk({tag, "_b_err"}, {b_done, b_timeout, b_core_reset, b_wr_ready}, 4'b0111);
    check_digest(tag);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; start = 1'b0; rd_idx = '0;
    core_ready = 1'b0; core_hash = '0;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    chk("rst_ctrl", {a_core_reset, a_wr_ready, a_busy, a_done, a_timeout}, 5'b11000);
    chk("rst_msg", a_core_message, 512'h0);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      chk($sformatf("rst_rd%0d", i), a_rd_data, 32'h0);
    end
    chk("rst_b_ctrl", {b_core_reset, b_wr_ready, b_busy, b_timeout}, 4'b1100);

    // nominal "abc" job
    for (int k = 0; k < 16; k++) msg_w[k] = 32'h0;
    msg_w[0]  = 32'h61626380;
    msg_w[15] = 32'h00000018;
    build_exp();
    hw[0] = 32'hba7816bf; hw[1] = 32'h8f01cfea; hw[2] = 32'h414140de; hw[3] = 32'h5dae2223;
    hw[4] = 32'hb00361a3; hw[5] = 32'h96177a9c; hw[6] = 32'hb410ff61; hw[7] = 32'hf20015ad;
    core_hash = {hw[0], hw[1], hw[2], hw[3], hw[4], hw[5], hw[6], hw[7]};
    for (int k = 0; k < 16; k++) write_word(msg_w[k]);
    chk("abc_loaded_ready", {a_wr_ready, a_busy}, 2'b00);
    chk("abc_msg", a_core_message, exp_msg);
    run_job(64, 1'b0, "abc");

    // start in DONE is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_ignored", {a_busy, a_done}, 2'b01);

    // reload after DONE/ERR, early start ignored
    random_block();
    random_hash();
    write_word(msg_w[0]);
    chk("reload_clear", {a_done, a_wr_ready, b_timeout, b_wr_ready}, 4'b0101);
    for (int k = 1; k < 15; k++) write_word(msg_w[k]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("early_start", {a_busy, a_wr_ready}, 2'b01);
    wr_valid = 1'b1; wr_data = msg_w[15]; start = 1'b1;
    tick();
    wr_valid = 1'b0; start = 1'b0;
    chk("start_with_last", {a_busy, a_wr_ready, b_busy, b_wr_ready}, 4'b0000);
    tick();
    chk("start_with_last_idle", a_busy, 1'b0);
    chk("reload_msg", a_core_message, exp_msg);
    chk("reload_b_msg", b_core_message, exp_msg);
    run_job($urandom_range(9, 80), 1'b0, "reload");

    // stale ready held high across the launch
    random_block();
    random_hash();
    for (int k = 0; k < 16; k++) write_word(msg_w[k]);
    chk("stale_msg", a_core_message, exp_msg);
    core_ready = 1'b1;
    run_job(2, 1'b1, "stale");
    core_ready = 1'b0;

    // reset in the middle of RUN
    random_block();
    random_hash();
    for (int k = 0; k < 16; k++) write_word(msg_w[k]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RST_A + 4) tick();
    chk("midrun_running", {a_busy, a_core_reset}, 2'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun_rst_ctrl", {a_core_reset, a_wr_ready, a_busy, a_done, a_timeout}, 5'b11000);
    chk("midrun_rst_msg", a_core_message, 512'h0);
    rd_idx = 3'($urandom_range(0, 7));
    #1;
    chk("midrun_rst_rd", a_rd_data, 32'h0);
    chk("midrun_rst_b", {b_busy, b_timeout, b_core_reset}, 3'b001);
    random_block();
    random_hash();
    for (int k = 0; k < 16; k++) write_word(msg_w[k]);
    chk("after_rst_msg", a_core_message, exp_msg);
    run_job($urandom_range(2, 90), 1'b0, "after_rst");

    // randomized jobs
    for (int j = 0; j < 4; j++) begin
      random_block();
      random_hash();
      for (int k = 0; k < 16; k++) write_word(msg_w[k]);
      chk($sformatf("rand%0d_msg", j), a_core_message, exp_msg);
      run_job($urandom_range(2, 90), 1'b0, $sformatf("rand%0d", j));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha_job_sequencer.md
# sha_job_sequencer

Sequencer that owns the `overall` SHA-256 core and runs one 512-bit block per job. It accepts 16 message words over a valid/ready stream, assembles them into the core's message bus, and pulses the core reset on `start`. It then waits for the core's `ready` with a timeout watchdog, captures the 256-bit digest and serves it as eight 32-bit words. It sits between the AXI peripheral register decode and the core, replacing software-driven reset/poll sequencing.

## Interface
- `RESET_CYCLES`, default 2: cycles `core_reset` is held high at job start; legal range 1..15.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles spent in RUN before the job is aborted; ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_valid` in 1: message word valid.
- `wr_ready` out 1: sequencer accepts a word.
- `wr_data` in 32: message word, in order word0..word15.
- `start` in 1: single-cycle job launch request.
- `busy` out 1: high in RST and RUN.
- `done` out 1: digest captured; level output.
- `timeout` out 1: job aborted by watchdog; level output.
- `rd_idx` in 3: digest word select.
- `rd_data` out 32: combinational read of the captured digest word.
- `core_message` out [0:511]: message bus to the core.
- `core_reset` out 1: reset to the core.
- `core_ready` in 1: core completion flag.
- `core_hash` in 256: core digest.

## Operation
- States: IDLE, LOADED, RST, RUN, DONE, ERR.
- Word counter `wcnt` runs 0..16.
- Accepted word k is written to `core_message[32k : 32k+31]`. Word0 lands in bits [0:31].
- A word is accepted on `wr_valid && wr_ready`.
- `wr_ready` is high in IDLE when `wcnt < 16`, and in DONE and ERR. It is low otherwise.
- IDLE → LOADED when the 16th word is accepted.
- A word accepted in DONE or ERR starts a new load:
  - it is stored as word0 and sets `wcnt = 1`;
  - it clears `done` and `timeout`;
  - the state moves to IDLE.
- `start` is honoured only in LOADED (→ RST). It is ignored in every other state, including IDLE with `wcnt = 15` while the 16th word is accepted in the same cycle.
- RST: holds `core_reset` high for exactly `RESET_CYCLES` cycles, then → RUN. The cycle counter is cleared.
- RUN behaviour:
  - `core_reset` is low.
  - `core_ready` is ignored in the first RUN cycle, which masks a stale ready from the previous job.
  - From the second RUN cycle on, `core_ready` high latches `core_hash` into the digest register and moves to DONE.
  - If the cycle counter reaches `TIMEOUT_CYCLES` without qualified ready, the state goes to ERR.
- DONE: `done` = 1. `core_reset` stays low. The digest is stable.
- ERR: `timeout` = 1 and `core_reset` = 1. The digest register keeps its previous content.
- Re-running the same message: `start` in DONE/ERR is ignored. Reloading all 16 words is required.
- `core_reset` is high in IDLE, LOADED, RST and ERR, and low in RUN and DONE.
- `rd_data` = `digest[255-32*rd_idx -: 32]`. Index 0 is the most significant word.

## Timing
- Reset values:
  - state IDLE, `wcnt` 0;
  - `wr_ready` 1, `busy` 0, `done` 0, `timeout` 0, `core_reset` 1;
  - digest 0, so `rd_data` = 0;
  - `core_message` 0.
- Reset mid-job from any state forces all of the above next cycle. The core is held in reset.
- `start` sampled at edge t:
  - RST during cycles t+1 .. t+RESET_CYCLES;
  - RUN from t+RESET_CYCLES+1;
  - `busy` high over the same span.
- Qualified `core_ready` at edge r → digest valid and `done` = 1 from r+1. `busy` falls at r+1.
- Timeout: ERR entered one cycle after RUN cycle `TIMEOUT_CYCLES`.
- Load path has no bubbles: one word per cycle at full throughput.
- `rd_data` has zero latency (combinational from the register and `rd_idx`).

## Structure
- Shared package `sha_ctrl_pkg` holds:
  - the state enum;
  - `SHA_MSG_WORDS = 16`, `SHA_HASH_WORDS = 8`;
  - `SHA_WORD_W = 32`.
- Single module; no sub-module is warranted.
- Counter widths: `$clog2(TIMEOUT_CYCLES+1)` for the cycle counter, 5 bits for `wcnt`.

## Test plan
- **Reset values:** assert `reset` 3 cycles → `core_reset` = 1, `wr_ready` = 1, `busy`/`done`/`timeout` = 0, `rd_data` = 0 for all idx.
- **Nominal job:** stream the 16-word padded "abc" block, pulse `start`, model core raises ready 64 cycles into RUN → `busy` for 2+64 cycles. `done` is set next cycle. `rd_idx` 0..7 yields `ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad`.
- **Early start:** `start` with 15 words loaded → ignored (`busy` stays 0). Load word16, then `start` → job runs.
- **Timeout:** `TIMEOUT_CYCLES` = 8, model never asserts ready:
  - ERR after 8 RUN cycles, `timeout` = 1, `core_reset` = 1;
  - next word write clears `timeout`, `wcnt` = 1.
- **Stale ready:** `core_ready` held high from the previous job → ignored in the first RUN cycle; capture occurs on the second RUN cycle.
- **Reset mid-RUN:** assert `reset` during RUN → next cycle IDLE, `core_reset` = 1, `done` = 0. A subsequent full load and `start` completes normally.
